// File: rtl/btb_assoc_if.sv
// IF-stage lookup and EX-stage update bundle for the branch target buffer.
interface btb_assoc_if;
  logic [31:0] pc_lookup;
  logic        btb_hit;
  logic        btb_predict_taken;
  logic [31:0] btb_target;
  logic        update_en;
  logic [31:0] pc_update;
  logic [31:0] actual_target;
  logic        actual_taken;
  logic        flush;

  modport master (
    output pc_lookup, update_en, pc_update, actual_target, actual_taken, flush,
    input  btb_hit, btb_predict_taken, btb_target
  );

  modport slave (
    input  pc_lookup, update_en, pc_update, actual_target, actual_taken, flush,
    output btb_hit, btb_predict_taken, btb_target
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB with saturating direction counters; BTB_FWD_EN adds a same-cycle update bypass.
// Latency: lookup is combinational (zero cycles); an update is visible the cycle after its edge.
// Backpressure: none; a lookup and an update are accepted every cycle, flush drops a concurrent update.
module btb_assoc #(
  parameter int NUM_SETS = 32,
  parameter int NUM_WAYS = 2,
  parameter int CTR_BITS = 2
) (
  input logic       clk,
  input logic       rst_n,
  btb_assoc_if.slave bus
);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] tag_q    [NUM_SETS][NUM_WAYS];
  logic [31:0]         target_q [NUM_SETS][NUM_WAYS];
  logic [CTR_BITS-1:0] ctr_q    [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] rr_q     [NUM_SETS];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic [NUM_WAYS-1:0] lk_match, up_match;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] lk_ctr, up_ctr, up_ctr_next;
  logic [31:0]         lk_tgt;
  logic                up_inv_any;
  logic [WAY_BITS-1:0] up_inv_way, victim;

  logic                out_hit;
  logic [CTR_BITS-1:0] out_ctr;
  logic [31:0]         out_tgt;

  // Only one way can match, so an AND-OR mux is sufficient.
  always_comb begin
    lk_idx   = bus.pc_lookup[IDX_BITS+1:2];
    lk_tag   = bus.pc_lookup[31:IDX_BITS+2];
    lk_match = '0;
    lk_hit   = 1'b0;
    lk_ctr   = '0;
    lk_tgt   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
      lk_hit      = lk_hit | lk_match[w];
      lk_ctr      = lk_ctr | ({CTR_BITS{lk_match[w]}} & ctr_q[lk_idx][w]);
      lk_tgt      = lk_tgt | ({32{lk_match[w]}} & target_q[lk_idx][w]);
    end
  end

  always_comb begin
    up_idx     = bus.pc_update[IDX_BITS+1:2];
    up_tag     = bus.pc_update[31:IDX_BITS+2];
    up_match   = '0;
    up_hit     = 1'b0;
    up_ctr     = '0;
    up_inv_any = 1'b0;
    up_inv_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
      up_hit      = up_hit | up_match[w];
      up_ctr      = up_ctr | ({CTR_BITS{up_match[w]}} & ctr_q[up_idx][w]);
      if (!valid_q[up_idx][w]) begin
        up_inv_any = 1'b1;
        up_inv_way = WAY_BITS'(w);
      end
    end
    victim = up_inv_any ? up_inv_way : rr_q[up_idx];
    if (bus.actual_taken) up_ctr_next = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + 1'b1;
    else                  up_ctr_next = (up_ctr == '0) ? up_ctr : up_ctr - 1'b1;
  end

`ifdef BTB_FWD_EN
  logic fwd;
  assign fwd = rst_n && bus.update_en && !bus.flush &&
               (bus.pc_update[31:2] == bus.pc_lookup[31:2]);

  // Same entry as the lookup: present the post-update view this cycle.
  always_comb begin
    out_hit = lk_hit;
    out_ctr = lk_ctr;
    out_tgt = lk_tgt;
    if (fwd) begin
      if (up_hit) begin
        out_ctr = up_ctr_next;
        if (bus.actual_taken) out_tgt = bus.actual_target;
      end else if (bus.actual_taken) begin
        out_hit = 1'b1;
        out_ctr = CTR_INIT;
        out_tgt = bus.actual_target;
      end
    end
  end
`else
  always_comb begin
    out_hit = lk_hit;
    out_ctr = lk_ctr;
    out_tgt = lk_tgt;
  end
`endif

  assign bus.btb_hit           = out_hit;
  assign bus.btb_predict_taken = out_hit & out_ctr[CTR_BITS-1];
  assign bus.btb_target        = out_hit ? out_tgt : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.pc_lookup[1:0], bus.pc_update[1:0], out_ctr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w]  <= 1'b0;
          tag_q[s][w]    <= '0;
          target_q[s][w] <= '0;
          ctr_q[s][w]    <= '0;
        end
      end
    end else if (bus.flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (bus.update_en) begin
      if (up_hit) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (up_match[w]) begin
            ctr_q[up_idx][w] <= up_ctr_next;
            if (bus.actual_taken) target_q[up_idx][w] <= bus.actual_target;
          end
        end
      end else if (bus.actual_taken) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (victim == WAY_BITS'(w)) begin
            valid_q[up_idx][w]  <= 1'b1;
            tag_q[up_idx][w]    <= up_tag;
            target_q[up_idx][w] <= bus.actual_target;
            ctr_q[up_idx][w]    <= CTR_INIT;
          end
        end
        // Round-robin pointer moves only when a valid entry is evicted.
        if (NUM_WAYS > 1 && !up_inv_any) rr_q[up_idx] <= rr_q[up_idx] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Randomised + directed scoreboard bench for btb_assoc against an array-based reference model.
module tb_btb_assoc;
  localparam int NSETS = 32;
  localparam int NWAYS = 2;
  localparam int CTRB  = 2;
  localparam int IDXB  = $clog2(NSETS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_assoc_if bif();

  btb_assoc #(.NUM_SETS(NSETS), .NUM_WAYS(NWAYS), .CTR_BITS(CTRB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif.slave)
  );

  // Reference model state
  bit          m_valid [NSETS][NWAYS];
  int unsigned m_tag   [NSETS][NWAYS];
  logic [31:0] m_tgt   [NSETS][NWAYS];
  int          m_ctr   [NSETS][NWAYS];
  int          m_rr    [NSETS];

  bit          q_hit [$];
  bit          q_pt  [$];
  logic [31:0] q_tgt [$];
  string       q_nm  [$];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = 0;
      end
    end
  endfunction

  function automatic int find_way(input logic [31:0] pc);
    int s = int'((pc >> 2) % NSETS);
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == (pc >> (IDXB + 2))) return w;
    return -1;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit hit, output bit pt,
                                       output logic [31:0] tgt);
    int s = int'((pc >> 2) % NSETS);
    int w = find_way(pc);
    hit = (w >= 0);
    pt  = hit && (m_ctr[s][w] >= 2 ** (CTRB - 1));
    tgt = hit ? m_tgt[s][w] : 32'h0;
  endfunction

  function automatic void model_update(input bit ue, input logic [31:0] pc, input logic [31:0] at,
                                       input bit tk, input bit fl);
    int s = int'((pc >> 2) % NSETS);
    int w = find_way(pc);
    int v = -1;
    if (fl) begin
      for (int i = 0; i < NSETS; i++) begin
        m_rr[i] = 0;
        for (int j = 0; j < NWAYS; j++) m_valid[i][j] = 0;
      end
      return;
    end
    if (!ue) return;
    if (w >= 0) begin
      if (tk) begin
        m_ctr[s][w] = (m_ctr[s][w] + 1 > 2 ** CTRB - 1) ? 2 ** CTRB - 1 : m_ctr[s][w] + 1;
        m_tgt[s][w] = at;
      end else begin
        m_ctr[s][w] = (m_ctr[s][w] == 0) ? 0 : m_ctr[s][w] - 1;
      end
    end else if (tk) begin
      for (int j = NWAYS - 1; j >= 0; j--) if (!m_valid[s][j]) v = j;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NWAYS;
      end
      m_valid[s][v] = 1;
      m_tag[s][v]   = pc >> (IDXB + 2);
      m_tgt[s][v]   = at;
      m_ctr[s][v]   = 2 ** (CTRB - 1);
    end
  endfunction

  // One cycle of stimulus: called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic [31:0] lk, input bit ue, input logic [31:0] pu,
                     input logic [31:0] at, input bit tk, input bit fl, input string nm);
    bit hit, pt;
    logic [31:0] tgt;
    bit fwd = 0;
    bif.pc_lookup = lk; bif.update_en = ue; bif.pc_update = pu;
    bif.actual_target = at; bif.actual_taken = tk; bif.flush = fl;
`ifdef BTB_FWD_EN
    fwd = rst_n && ue && !fl && (pu[31:2] == lk[31:2]);
`endif
    if (fwd) begin
      model_update(ue, pu, at, tk, fl);
      model_lookup(lk, hit, pt, tgt);
    end else begin
      model_lookup(lk, hit, pt, tgt);
      if (rst_n) model_update(ue, pu, at, tk, fl);
    end
    q_hit.push_back(hit); q_pt.push_back(pt); q_tgt.push_back(tgt); q_nm.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic look(input logic [31:0] lk, input string nm);
    cyc(lk, 0, 32'h0, 32'h0, 0, 0, nm);
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_hit.size() > 0) begin
        bit eh, ep;
        logic [31:0] et;
        string nm;
        eh = q_hit.pop_front(); ep = q_pt.pop_front(); et = q_tgt.pop_front(); nm = q_nm.pop_front();
        n_cmp++;
        if (bif.btb_hit !== eh || bif.btb_predict_taken !== ep || bif.btb_target !== et) begin
          n_fail++;
          $display("FAIL %s: got hit=%b pt=%b tgt=%h, expected hit=%b pt=%b tgt=%h", nm,
                   bif.btb_hit, bif.btb_predict_taken, bif.btb_target, eh, ep, et);
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc, lpc;
    int wait_cnt;
    model_reset();
    bif.pc_lookup = 0; bif.update_en = 0; bif.pc_update = 0;
    bif.actual_target = 0; bif.actual_taken = 0; bif.flush = 0;
    @(posedge clk); #1;
    cyc(32'h100, 1, 32'h100, 32'h200, 1, 0, "reset_dominates");
    look(32'h100, "reset_state");
    rst_n = 1'b1;

    // Allocation and hysteresis
    cyc(32'h100, 1, 32'h100, 32'h200, 1, 0, "alloc_same_cycle");
    cyc(32'h100, 1, 32'h100, 32'h999, 0, 0, "alloc_visible");
    cyc(32'h100, 1, 32'h100, 32'h999, 0, 0, "ctr_01");
    cyc(32'h100, 1, 32'h100, 32'h204, 1, 0, "ctr_00");
    cyc(32'h100, 1, 32'h100, 32'h208, 1, 0, "ctr_01_up");
    look(32'h100, "ctr_10_predict");

    // Associativity and round-robin victim
    cyc(32'h180, 1, 32'h180, 32'h280, 1, 0, "way1_alloc");
    cyc(32'h200, 1, 32'h200, 32'h300, 1, 0, "evict_way0");
    look(32'h100, "evicted_miss");
    look(32'h180, "way1_hit");
    look(32'h200, "new_hit");

    // Not-taken miss
    cyc(32'h300, 1, 32'h304, 32'h400, 0, 0, "nt_miss_lookup");
    look(32'h304, "nt_miss_no_alloc");

    // Flush priority over update
    cyc(32'h180, 1, 32'h400, 32'h500, 1, 1, "flush_cycle");
    look(32'h180, "after_flush_180");
    look(32'h200, "after_flush_200");
    look(32'h400, "flush_dropped_update");

    // Asynchronous reset mid-cycle
    cyc(32'h0, 1, 32'h010, 32'h1010, 1, 0, "pop0");
    cyc(32'h0, 1, 32'h024, 32'h1024, 1, 0, "pop1");
    cyc(32'h0, 1, 32'h1038, 32'h1038, 1, 0, "pop2");
    cyc(32'h0, 1, 32'h2010, 32'h2010, 1, 0, "pop3");
    look(32'h010, "pop_check");
    bif.pc_lookup = 32'h024; bif.update_en = 0; bif.flush = 0;
    model_reset();
    q_hit.push_back(0); q_pt.push_back(0); q_tgt.push_back(32'h0); q_nm.push_back("async_reset");
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    look(32'h1038, "in_reset");
    rst_n = 1'b1;
    look(32'h010, "post_reset_010");
    look(32'h024, "post_reset_024");
    look(32'h1038, "post_reset_1038");
    look(32'h2010, "post_reset_2010");

    // Same-cycle lookup and update on a miss
    cyc(32'h500, 1, 32'h500, 32'hABC0, 1, 0, "same_cycle_500");
    look(32'h500, "next_cycle_500");

    // Randomised traffic over a few colliding sets and tags
    for (int i = 0; i < 400; i++) begin
      rpc = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      lpc = ($urandom_range(0, 3) == 0) ? rpc
            : 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2));
      cyc(lpc, $urandom_range(0, 9) < 6, rpc, $urandom, $urandom_range(0, 9) < 6,
          $urandom_range(0, 39) == 0, "random");
    end

    wait_cnt = 0;
    while (q_hit.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q_hit.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q_hit.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
